mips_boot_mem: RTL and testbench

//  Unified instruction/data memory and boot loader sitting directly downstream of the multicycle

---
 rtl/mips_boot_mem_if.sv | 49 ++++
 rtl/mips_boot_mem.sv | 132 +++++++++++++
 tb/tb_mips_boot_mem.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_boot_mem_if.sv
// +--------------------------------------------------------------------------+
// | mips_boot_mem_if                                                         |
// | Load-port and core memory-port bundle for mips_boot_mem.                 |
// | Optional trace signals exist only with MIPS_BOOT_MEM_TRACE_EN.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface mips_boot_mem_if #(
  parameter int WIDTH = 8
);
  logic             ld_valid;
  logic [7:0]       ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             ld_done;
  logic             core_reset;
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
`ifdef MIPS_BOOT_MEM_TRACE_EN
  logic             st_valid;
  logic [WIDTH-1:0] st_adr;
  logic [WIDTH-1:0] st_data;

  modport master (
    output ld_valid, ld_data, ld_last, memread, memwrite, adr, writedata,
    input  ld_ready, ld_done, core_reset, memdata, st_valid, st_adr, st_data
  );
  modport slave (
    input  ld_valid, ld_data, ld_last, memread, memwrite, adr, writedata,
    output ld_ready, ld_done, core_reset, memdata, st_valid, st_adr, st_data
  );
`else
  modport master (
    output ld_valid, ld_data, ld_last, memread, memwrite, adr, writedata,
    input  ld_ready, ld_done, core_reset, memdata
  );
  modport slave (
    input  ld_valid, ld_data, ld_last, memread, memwrite, adr, writedata,
    output ld_ready, ld_done, core_reset, memdata
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mips_boot_mem.sv
// +--------------------------------------------------------------------------+
// | mips_boot_mem                                                            |
// | Boot loader + unified byte RAM for the multicycle MIPS core.             |
// | Optional store trace: define MIPS_BOOT_MEM_TRACE_EN.                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mips_boot_mem #(
  parameter int WIDTH       = 8,
  parameter int ADDR_BITS   = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mips_boot_mem_if.slave bus
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_BITS:0] c_PTR_LAST = (ADDR_BITS+1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_BITS:0]   r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ld_ready;
  logic                 r_ld_done;
  logic                 r_core_reset;
  logic [7:0]           r_ram [DEPTH];

  logic                 w_ld_fire;
  logic                 w_ld_end;
  logic                 w_core_we;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_unused;

  assign w_idx     = bus.adr[ADDR_BITS-1:0];
  assign w_ld_fire = (r_state == S_LOAD) && r_ld_ready && bus.ld_valid;
  // Extra pointer bit keeps ptr from wrapping back onto RAM[0] after a full image.
  assign w_ld_end  = bus.ld_last || (r_ptr == c_PTR_LAST);
  assign w_core_we = (r_state == S_RUN) && bus.memwrite;
  assign w_unused  = ^{bus.adr, bus.writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_ld_ready   <= 1'b0;
      r_ld_done    <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_ld_ready <= 1'b1;
          if (w_ld_fire) begin
            r_ptr <= r_ptr + 1'b1;
            if (w_ld_end) begin
              r_state    <= S_HOLD;
              r_ld_ready <= 1'b0;
              r_cnt      <= '0;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == c_CNT_LAST) begin
            r_state      <= S_RUN;
            r_core_reset <= 1'b0;
            r_ld_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_ld_ready <= 1'b0;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  // Loader and core writes are exclusive by state, so one write port suffices.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_ram[r_ptr[ADDR_BITS-1:0]] <= bus.ld_data;
    end else if (w_core_we) begin
      r_ram[w_idx] <= bus.writedata[7:0];
    end
  end

  // Combinational read: the core captures memdata on the edge that ends memread.
  assign bus.memdata    = ((r_state == S_RUN) && bus.memread) ? WIDTH'(r_ram[w_idx]) : '0;
  assign bus.ld_ready   = r_ld_ready;
  assign bus.ld_done    = r_ld_done;
  assign bus.core_reset = r_core_reset;

`ifdef MIPS_BOOT_MEM_TRACE_EN
  logic             r_st_valid;
  logic [WIDTH-1:0] r_st_adr;
  logic [WIDTH-1:0] r_st_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_valid <= 1'b0;
      r_st_adr   <= '0;
      r_st_data  <= '0;
    end else begin
      r_st_valid <= w_core_we;
      if (w_core_we) begin
        r_st_adr  <= bus.adr;
        r_st_data <= bus.writedata;
      end
    end
  end

  assign bus.st_valid = r_st_valid;
  assign bus.st_adr   = r_st_adr;
  assign bus.st_data  = r_st_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_boot_mem.sv
// +--------------------------------------------------------------------------+
// | tb_mips_boot_mem                                                         |
// | Scoreboard bench: load, hold, run, reset and random RUN traffic.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mips_boot_mem;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic clk;
  logic reset;
  mips_boot_mem_if #(.WIDTH(WIDTH)) bus();

  mips_boot_mem #(
    .WIDTH(WIDTH), .ADDR_BITS(8), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference memory: what each byte must hold, and whether it has ever been written.
  logic [7:0] model [256];
  bit         known [256];
  int         mptr;
  bit         mload;
  bit         mrun;
  logic [7:0] expq [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.memread === 1'b1) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL memdata: read with no expectation, got %0h", bus.memdata);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (bus.memdata !== WIDTH'(e)) begin
          miscompares++;
          $display("FAIL memdata adr=%0h: got %0h, wanted %0h", bus.adr, bus.memdata, e);
        end
      end
    end
  end

  task automatic bus_cycle(bit rd, bit wr, logic [7:0] a, logic [7:0] d);
    bus.memread = rd; bus.memwrite = wr; bus.adr = a; bus.writedata = d;
    if (rd) expq.push_back(mrun ? model[a] : 8'h00);
    if (wr && mrun) begin model[a] = d; known[a] = 1'b1; end
    @(posedge clk); #1;
    bus.memread = 1'b0; bus.memwrite = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] d, bit last);
    bit rdy;
    int n;
    n = 0;
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    do begin
      @(negedge clk); rdy = bus.ld_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 20);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("ld_accept", 32'(rdy), 32'd1);
    if (rdy && mload) begin
      model[mptr] = d; known[mptr] = 1'b1;
      if (last || mptr == 255) mload = 1'b0;
      mptr++;
    end
  endtask

  task automatic idle_load();
    bus.ld_valid = 1'b0; bus.ld_data = 8'($urandom);
    @(posedge clk); #1;
  endtask

  // Called right after the final byte is accepted; release must come HOLD edges later.
  task automatic wait_run();
    chk("ld_ready_after_last", 32'(bus.ld_ready), 32'd0);
    chk("hold_core_reset", 32'(bus.core_reset), 32'd1);
    chk("hold_ld_done", 32'(bus.ld_done), 32'd0);
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge clk); #1;
      chk("release_ld_done", 32'(bus.ld_done), (k == HOLD) ? 32'd1 : 32'd0);
      chk("release_core_reset", 32'(bus.core_reset), (k == HOLD) ? 32'd0 : 32'd1);
    end
    mrun = 1'b1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    mptr = 0; mload = 1'b1; mrun = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img [4];
    reset = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.memread = 1'b0; bus.memwrite = 1'b0; bus.adr = '0; bus.writedata = '0;
    for (int i = 0; i < 256; i++) begin model[i] = '0; known[i] = 1'b0; end
    mptr = 0; mload = 1'b1; mrun = 1'b0;
    #1;
    chk("init_core_reset", 32'(bus.core_reset), 32'd1);
    chk("init_ld_done", 32'(bus.ld_done), 32'd0);
    chk("init_ld_ready", 32'(bus.ld_ready), 32'd0);
    #21 reset = 1'b0;
    @(posedge clk); #1;

    // Basic image with ld_last on the fourth byte.
    send_byte(8'h80, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0); send_byte(8'h20, 1'b1);
    wait_run();
    for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 8'(i), 8'h00);

    // Store then load, then same-cycle read and write.
    bus_cycle(1'b0, 1'b1, 8'h10, 8'h5A);
    bus_cycle(1'b1, 1'b0, 8'h10, 8'h00);
    bus_cycle(1'b1, 1'b1, 8'h10, 8'hA5);
    bus_cycle(1'b1, 1'b0, 8'h10, 8'h00);

    bus_cycle(1'b0, 1'b1, 8'h21, 8'h33);
`ifdef MIPS_BOOT_MEM_TRACE_EN
    chk("st_valid_pulse", 32'(bus.st_valid), 32'd1);
    chk("st_adr", 32'(bus.st_adr), 32'h21);
    chk("st_data", 32'(bus.st_data), 32'h33);
    bus_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    chk("st_valid_drop", 32'(bus.st_valid), 32'd0);
    chk("st_adr_hold", 32'(bus.st_adr), 32'h21);
`endif

    // Reset mid-run, a read and a stray write during LOAD, then a partial load aborted.
    pulse_reset();
    bus_cycle(1'b1, 1'b1, 8'h10, 8'h77);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    pulse_reset();

    // Reload with gaps in ld_valid.
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    send_byte(img[0], 1'b0); idle_load();
    send_byte(img[1], 1'b0); send_byte(img[2], 1'b0); idle_load();
    send_byte(img[3], 1'b1);
    wait_run();
    for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 8'(i), 8'h00);
    bus_cycle(1'b1, 1'b0, 8'h10, 8'h00);
    bus_cycle(1'b1, 1'b0, 8'h21, 8'h00);

    // Full-depth image without ld_last; surplus bytes must be ignored.
    pulse_reset();
    for (int i = 0; i < 256; i++) send_byte(8'($urandom), 1'b0);
    bus.ld_valid = 1'b1; bus.ld_data = 8'hEE; bus.ld_last = 1'b1;
    wait_run();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    bus_cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    bus_cycle(1'b1, 1'b0, 8'h00, 8'h00);

    // Random RUN traffic with loader noise.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      bus.ld_valid = 1'($urandom); bus.ld_data = 8'($urandom); bus.ld_last = 1'($urandom);
      bus_cycle(1'($urandom) & known[a], 1'($urandom), a, 8'($urandom));
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("run_ld_done", 32'(bus.ld_done), 32'd1);
    chk("run_core_reset", 32'(bus.core_reset), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
